// File: rtl/instr_queue_pkg.sv
// Shared datapath sizes for the fetch path.
// Instruction width and default queue depth.
package instr_queue_pkg;

  localparam int IWIDTH   = 32;
  localparam int IQ_DEPTH = 8;

endpackage

// File: rtl/instr_queue_storage.sv
// Instruction queue register file: DEPTH x WIDTH,
// one synchronous write port, one asynchronous read port.
module iq_storage #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and decode.
// Ports: iq_clk/iq_rst, flush, push/pop, head, full, count, overflow.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int AW    = 3
) (
  input  logic              iq_clk,
  input  logic              iq_rst,
  input  logic              iq_i_flush,
  input  logic              iq_i_wr_en,
  input  logic [IWIDTH-1:0] iq_i_wr_instr,
  input  logic              iq_i_rd_en,
  output logic              iq_o_check_queue,
  output logic [IWIDTH-1:0] iq_o_queue_instr,
  output logic              iq_o_full,
  output logic [AW:0]       iq_o_count,
  output logic              iq_o_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              overflow;
  logic              full;
  logic              not_empty;
  logic              push_ok;
  logic              pop_ok;
  logic              mem_we;
  logic [IWIDTH-1:0] head;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);

  // A push into a full queue is fine when the head
  // leaves in the same cycle: the freed slot is reused.
  assign pop_ok  = iq_i_rd_en && not_empty;
  assign push_ok = iq_i_wr_en && (!full || pop_ok);
  assign mem_we  = push_ok && !iq_rst && !iq_i_flush;

  iq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (IWIDTH)
  ) u_storage (
    .clk   (iq_clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (iq_i_wr_instr),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge iq_clk) begin
    if (iq_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (iq_i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (iq_i_wr_en && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign iq_o_check_queue = not_empty;
  assign iq_o_queue_instr = not_empty ? head : '0;
  assign iq_o_full        = full;
  assign iq_o_count       = count;
  assign iq_o_overflow    = overflow;

endmodule

// File: tb/tb_instr_queue.sv
// Directed table-driven bench for instr_queue.
// Each record: inputs for one edge, outputs expected after it.
module tb_instr_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_instr;
  logic        rd_en;
  logic        check_queue;
  logic [31:0] queue_instr;
  logic        full;
  logic [3:0]  count;
  logic        overflow;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        wr;
    logic [31:0] d;
    logic        rd;
    logic [3:0]  cnt;
    logic        chk;
    logic [31:0] ins;
    logic        full;
    logic        ovf;
  } vec_t;

  vec_t vq[$];

  instr_queue #(
    .DEPTH (8),
    .AW    (3)
  ) dut (
    .iq_clk           (clk),
    .iq_rst           (rst),
    .iq_i_flush       (flush),
    .iq_i_wr_en       (wr_en),
    .iq_i_wr_instr    (wr_instr),
    .iq_i_rd_en       (rd_en),
    .iq_o_check_queue (check_queue),
    .iq_o_queue_instr (queue_instr),
    .iq_o_full        (full),
    .iq_o_count       (count),
    .iq_o_overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic f, input logic w,
    input logic [31:0] d, input logic rd,
    input int cnt, input logic chk,
    input logic [31:0] ins, input logic fl, input logic ov
  );
    vec_t v;
    v.rst  = r;
    v.flush = f;
    v.wr   = w;
    v.d    = d;
    v.rd   = rd;
    v.cnt  = 4'(cnt);
    v.chk  = chk;
    v.ins  = ins;
    v.full = fl;
    v.ovf  = ov;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    rst      = v.rst;
    flush    = v.flush;
    wr_en    = v.wr;
    wr_instr = v.d;
    rd_en    = v.rd;
    @(posedge clk);
    #1;
    cmp("count",    idx, 32'(count),       32'(v.cnt));
    cmp("check_q",  idx, 32'(check_queue), 32'(v.chk));
    cmp("instr",    idx, queue_instr,      v.ins);
    cmp("full",     idx, 32'(full),        32'(v.full));
    cmp("overflow", idx, 32'(overflow),    32'(v.ovf));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    wr_en    = 1'b0;
    wr_instr = '0;
    rd_en    = 1'b0;

    // Reset held two cycles with a push pending.
    vq.push_back(mk(1,0,1,32'h11,0, 0,0,0,0,0));
    vq.push_back(mk(1,0,1,32'h22,0, 0,0,0,0,0));
    // Push then pop.
    vq.push_back(mk(0,0,1,32'hcafecafe,0, 1,1,32'hcafecafe,0,0));
    vq.push_back(mk(0,0,1,32'hfafafafa,0, 2,1,32'hcafecafe,0,0));
    vq.push_back(mk(0,0,0,0,1, 1,1,32'hfafafafa,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0,0));
    // Pop while empty is ignored.
    vq.push_back(mk(0,0,0,0,1, 0,0,0,0,0));
    // Fill with 1..8, then a dropped 9th push.
    for (int k = 1; k <= 8; k++)
      vq.push_back(mk(0,0,1,32'(k),0, k,1,32'h1,(k == 8),0));
    vq.push_back(mk(0,0,1,32'h9,0, 8,1,32'h1,1,1));
    // Drain: head after each pop is the next word in order.
    for (int i = 1; i <= 8; i++)
      vq.push_back(mk(0,0,0,0,1, 8-i,(i < 8),
                      (i < 8) ? 32'(i+1) : 32'h0,0,1));
    // Reset clears overflow.
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
    // Refill, then push and pop together while full.
    for (int k = 1; k <= 8; k++)
      vq.push_back(mk(0,0,1,32'h100+32'(k),0,
                      k,1,32'h101,(k == 8),0));
    vq.push_back(mk(0,0,1,32'hAA,1, 8,1,32'h102,1,0));
    for (int i = 1; i <= 8; i++)
      vq.push_back(mk(0,0,0,0,1, 8-i,(i < 8),
                      (i <= 6) ? 32'h102+32'(i) :
                      (i == 7) ? 32'hAA : 32'h0,0,0));
    // Five entries, then flush with push and pop asserted.
    for (int k = 1; k <= 5; k++)
      vq.push_back(mk(0,0,1,32'h200+32'(k),0, k,1,32'h201,0,0));
    vq.push_back(mk(0,1,1,32'h2FF,1, 0,0,0,0,0));
    vq.push_back(mk(0,0,1,32'hdeadbeef,0, 1,1,32'hdeadbeef,0,0));
    // Overflow survives a flush.
    for (int k = 2; k <= 8; k++)
      vq.push_back(mk(0,0,1,32'h300+32'(k),0,
                      k,1,32'hdeadbeef,(k == 8),0));
    vq.push_back(mk(0,0,1,32'h3FF,0, 8,1,32'hdeadbeef,1,1));
    vq.push_back(mk(0,1,0,0,0, 0,0,0,0,1));
    vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));

    foreach (vq[i]) step(vq[i], i);

    // Wrap-around: 20 push/pop pairs, count never above 1.
    for (int n = 0; n < 20; n++) begin
      vec_t v;
      logic [31:0] w;
      w = 32'h5000 + 32'(n);
      v = mk(0,0,1,w,0, 1,1,w,0,0);
      step(v, 1000 + 2*n);
      v = mk(0,0,0,0,1, 0,0,0,0,0);
      step(v, 1001 + 2*n);
    end

    rd_en = 1'b0;
    wr_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Circular instruction FIFO that buffers fetched instructions the decode stage cannot take in the cycle they arrive. It is the producer side of the fetch-select path. `iq_o_check_queue` and `iq_o_queue_instr` drive `mx_i_check_queue` and `mx_i_queue_instr` of `mux2_1_check_queue`, so decode reads from the queue whenever it is non-empty and from memory otherwise. Fetch is stalled via `iq_o_full`; a branch redirect empties the queue via `iq_i_flush`.

## Interface
- `DEPTH`, default 8: number of entries; power of two, ≥ 2.
- `AW`, default 3: pointer width, equal to log2(`DEPTH`).
- `iq_clk`  in  1: clock; all state updates on the rising edge.
- `iq_rst`  in  1: synchronous, active-high reset.
- `iq_i_flush`  in  1: discard all entries (branch mispredict / redirect).
- `iq_i_wr_en`  in  1: push `iq_i_wr_instr` at the tail.
- `iq_i_wr_instr`  in  `IWIDTH`: instruction word from instruction memory.
- `iq_i_rd_en`  in  1: decode consumed the head entry this cycle.
- `iq_o_check_queue`  out  1: 1 when count ≠ 0; selects the queue path in the mux.
- `iq_o_queue_instr`  out  `IWIDTH`: head entry; 0 when empty.
- `iq_o_full`  out  1: 1 when count == `DEPTH`.
- `iq_o_count`  out  `AW`+1: number of valid entries, 0..`DEPTH`.
- `iq_o_overflow`  out  1: sticky; set by a push that was dropped because the queue was full.

## Operation
- State:
  - `rd_ptr` and `wr_ptr`, each `AW` bits, wrap modulo `DEPTH` naturally.
  - `count`, `AW`+1 bits.
  - Storage array of `DEPTH` × `IWIDTH`.
- Event priority per edge, highest first: `iq_rst` > `iq_i_flush` > push/pop.
- Reset:
  - Pointers and count go to 0; `iq_o_overflow` goes to 0; storage is not cleared.
  - Outputs after reset: `check_queue`=0, `queue_instr`=0, `full`=0, `count`=0, `overflow`=0.
- Flush:
  - Pointers and count go to 0; a push or pop in the same cycle is ignored.
  - `overflow` is kept; only reset clears it.
- Effective push: `wr_en` && (!full || effective pop). Effective pop: `rd_en` && count ≠ 0.
- Push only: write storage[`wr_ptr`], `wr_ptr`+1, count+1.
- Pop only: `rd_ptr`+1, count−1.
- Push and pop together: both pointers advance and count is unchanged. This is legal when full, and the freed head slot is reused.
- Push while full without a pop: the data is dropped, state is unchanged, and `overflow` is set to 1.
- Pop while empty: ignored, no underflow.
- Push while empty: the instruction enters the queue. Fetch is responsible for not pushing a word that decode took directly from memory the same cycle.
- `queue_instr` = storage[`rd_ptr`] when count ≠ 0, else 0.
- `full` and `check_queue` are decoded combinationally from the registered count.

## Timing
- Push-to-visible latency is 1 cycle. A word pushed at edge N appears on `queue_instr` after edge N if it is the new head, and `check_queue` rises after edge N.
- Pop takes effect at the edge; the next entry appears on `queue_instr` in the same cycle it becomes the head.
- All outputs are glitch-free functions of registered state only. There is no combinational path from any input to any output.
- Flush is effective at the next edge: `check_queue`=0 in the cycle after `iq_i_flush`.
- Pointer wrap from `DEPTH`−1 to 0 needs no special case.

## Structure
- `IWIDTH` (32) and `IQ_DEPTH` (8) belong in the shared define header that the mux and the other datapath files include.
- A single sub-module is natural: `iq_storage`, a `DEPTH`×`IWIDTH` register file with one synchronous write port and one asynchronous read port. Pointer and count logic stays in `instr_queue`.

## Test plan
- Reset:
  - Stimulus: hold `iq_rst`=1 for 2 cycles with `wr_en`=1.
  - Required: `count`=0, `check_queue`=0, `queue_instr`=32'h0, `full`=0, `overflow`=0.
- Push then pop:
  - Stimulus: push 32'hcafecafe, then 32'hfafafafa.
  - Required: `queue_instr`=cafecafe with `count`=2. After one pop, `queue_instr`=fafafafa and `count`=1. After the second pop, `check_queue`=0 and `queue_instr`=0.
- Fill and overflow:
  - Stimulus: push 8 words 32'h1..32'h8, then push 32'h9.
  - Required: `full`=1 after the 8th push. The 9th push is dropped with `overflow`=1. Popping all 8 returns 1..8 in order.
- Full with simultaneous push/pop:
  - Stimulus: when full, assert `wr_en` (32'hAA) and `rd_en` together.
  - Required: `count` stays 8, `overflow` stays 0, and 32'hAA comes out last.
- Wrap-around:
  - Stimulus: run 20 interleaved push/pop pairs with incrementing data.
  - Required: output order matches input order across pointer wrap, and `count` never exceeds 1.
- Flush:
  - Stimulus: with 5 entries, assert `iq_i_flush` together with `wr_en` and `rd_en`.
  - Required: next cycle `count`=0 and `check_queue`=0. A subsequent push of 32'hdeadbeef appears at the head.
